// File: rtl/age_select_pkg.sv
// Shared backend types for the reservation-station select path.
package age_select_pkg;

  localparam int unsigned RS_ENTRIES = 8;
  localparam int unsigned NUM_FUS    = 1;
  localparam int unsigned RS_IDX_W   = $clog2(RS_ENTRIES);

  typedef logic [RS_IDX_W-1:0] rs_idx_t;

endpackage

// File: rtl/age_select_age_matrix.sv
// Age matrix over RS entries: tracks allocation order and picks the oldest
// requesting entry as a one-hot vector.
module age_matrix #(
  parameter int unsigned N = age_select_pkg::RS_ENTRIES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_alloc_valid,
  input  age_select_pkg::rs_idx_t  i_alloc_entry,
  input  logic                     i_retire_valid,
  input  age_select_pkg::rs_idx_t  i_retire_entry,
  input  logic [N-1:0]             i_eff,
  output logic [N-1:0]             o_entry_valid,
  output logic [N-1:0]             o_oldest_c
);
  import age_select_pkg::*;

  logic [N-1:0]          r_entry_valid;
  logic [N-1:0][N-1:0]   r_older;
  logic [N-1:0]          w_valid_nxt;
  logic [N-1:0][N-1:0]   w_older_nxt;
  logic [N-1:0]          w_win;
  logic                  w_retire_apply;
  logic                  w_found;

  // A same-index alloc overrides the retire.
  assign w_retire_apply = i_retire_valid &&
                          !(i_alloc_valid && (i_alloc_entry == i_retire_entry));

  always_comb begin
    w_valid_nxt = r_entry_valid;
    w_older_nxt = r_older;
    if (i_alloc_valid) begin
      w_valid_nxt[i_alloc_entry] = 1'b1;
      for (int i = 0; i < int'(N); i++) begin
        w_older_nxt[i_alloc_entry][i] = 1'b0;
        if (rs_idx_t'(i) != i_alloc_entry) begin
          w_older_nxt[i][i_alloc_entry] = r_entry_valid[i];
        end
      end
    end
    if (w_retire_apply) begin
      w_valid_nxt[i_retire_entry] = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        w_older_nxt[i_retire_entry][i] = 1'b0;
        w_older_nxt[i][i_retire_entry] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entry_valid <= '0;
      r_older       <= '0;
    end else begin
      r_entry_valid <= w_valid_nxt;
      r_older       <= w_older_nxt;
    end
  end

  // Entry wins when no older entry is also requesting; lowest index breaks ties.
  always_comb begin
    w_win      = i_eff;
    o_oldest_c = '0;
    w_found    = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      for (int j = 0; j < int'(N); j++) begin
        if (i_eff[j] && r_older[j][i]) begin
          w_win[i] = 1'b0;
        end
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (w_win[i] && !w_found) begin
        o_oldest_c[i] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

  assign o_entry_valid = r_entry_valid;

endmodule

// File: rtl/age_select.sv
// Oldest-first select for a reservation station, feeding a single issue
// register with a valid/ready handshake and a handshake counter.
module age_select #(
  parameter int unsigned RS_ENTRIES = age_select_pkg::RS_ENTRIES,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_valid,
  input  age_select_pkg::rs_idx_t  alloc_entry,
  input  logic [RS_ENTRIES-1:0]    reqs,
  input  logic                     retire_valid,
  input  age_select_pkg::rs_idx_t  retire_entry,
  input  logic                     issue_ready,
  output logic                     grant_valid,
  output age_select_pkg::rs_idx_t  grant,
  output logic                     issue_valid,
  output age_select_pkg::rs_idx_t  issue_entry,
  output logic [CNT_W-1:0]         issue_count
);
  import age_select_pkg::*;

  logic [RS_ENTRIES-1:0] w_entry_valid;
  logic [RS_ENTRIES-1:0] w_eff;
  logic [RS_ENTRIES-1:0] w_oldest;
  rs_idx_t               w_win_idx;
  logic                  w_free;
  logic                  w_handshake;
  logic                  r_issue_valid;
  rs_idx_t               r_issue_entry;
  logic [CNT_W-1:0]      r_issue_count;

  age_matrix #(.N(RS_ENTRIES)) u_age_matrix (
    .clk            (clk),
    .rst_n          (rst),
    .i_alloc_valid  (alloc_valid),
    .i_alloc_entry  (alloc_entry),
    .i_retire_valid (retire_valid),
    .i_retire_entry (retire_entry),
    .i_eff          (w_eff),
    .o_entry_valid  (w_entry_valid),
    .o_oldest_c     (w_oldest)
  );

  assign w_eff       = reqs & w_entry_valid;
  assign w_free      = !r_issue_valid || issue_ready;
  assign w_handshake = r_issue_valid && issue_ready;

  // One-hot to index encode.
  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < int'(RS_ENTRIES); i++) begin
      if (w_oldest[i]) begin
        w_win_idx = w_win_idx | rs_idx_t'(i);
      end
    end
  end

  assign grant_valid = (|w_eff) && w_free;
  assign grant       = grant_valid ? w_win_idx : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_issue_valid <= 1'b0;
      r_issue_entry <= '0;
      r_issue_count <= '0;
    end else begin
      if (grant_valid) begin
        r_issue_valid <= 1'b1;
        r_issue_entry <= grant;
      end else if (w_handshake) begin
        r_issue_valid <= 1'b0;
      end
      r_issue_count <= r_issue_count + CNT_W'(w_handshake);
    end
  end

  assign issue_valid = r_issue_valid;
  assign issue_entry = r_issue_entry;
  assign issue_count = r_issue_count;

endmodule

// File: tb/tb_age_select.sv
// Directed self-checking bench for age_select with RS_ENTRIES=8, CNT_W=32.
module tb_age_select;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [2:0]  alloc_entry;
  logic [7:0]  reqs;
  logic        retire_valid;
  logic [2:0]  retire_entry;
  logic        issue_ready;
  logic        grant_valid;
  logic [2:0]  grant;
  logic        issue_valid;
  logic [2:0]  issue_entry;
  logic [31:0] issue_count;

  int checks   = 0;
  int failures = 0;

  age_select #(.RS_ENTRIES(8), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_entry  (alloc_entry),
    .reqs         (reqs),
    .retire_valid (retire_valid),
    .retire_entry (retire_entry),
    .issue_ready  (issue_ready),
    .grant_valid  (grant_valid),
    .grant        (grant),
    .issue_valid  (issue_valid),
    .issue_entry  (issue_entry),
    .issue_count  (issue_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [2:0] e);
    alloc_valid = 1'b1;
    alloc_entry = e;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic do_retire(input logic [2:0] e);
    retire_valid = 1'b1;
    retire_entry = e;
    tick();
    retire_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; alloc_valid = 1'b0; alloc_entry = '0; reqs = 8'hFF;
    retire_valid = 1'b0; retire_entry = '0; issue_ready = 1'b0;
    #2;
    checks++;
    if (grant_valid !== 1'b0 || grant !== 3'd0) begin
      failures++; $display("FAIL rst_grant gv=%0b g=%0d want 0/0", grant_valid, grant);
    end
    checks++;
    if (issue_valid !== 1'b0 || issue_entry !== 3'd0 || issue_count !== 32'd0) begin
      failures++;
      $display("FAIL rst_issue iv=%0b ie=%0d cnt=%0d want 0/0/0", issue_valid, issue_entry, issue_count);
    end
    #10;
    rst = 1'b1; reqs = 8'h00;
    alloc_valid = 1'b1; alloc_entry = 3'd5;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic test_age_order();
    logic [7:0] req_tab [3];
    logic [2:0] exp_tab [3];
    req_tab = '{8'hA4, 8'h84, 8'h80};
    exp_tab = '{3'd5, 3'd2, 3'd7};
    do_alloc(3'd2);
    do_alloc(3'd7);
    issue_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      reqs = req_tab[k];
      #1;
      checks++;
      if (grant_valid !== 1'b1 || grant !== exp_tab[k]) begin
        failures++; $display("FAIL age_grant%0d gv=%0b g=%0d want 1/%0d", k, grant_valid, grant, exp_tab[k]);
      end
      if (k > 0) begin
        checks++;
        if (issue_valid !== 1'b1 || issue_entry !== exp_tab[k-1]) begin
          failures++; $display("FAIL age_issue%0d iv=%0b ie=%0d want 1/%0d", k, issue_valid, issue_entry, exp_tab[k-1]);
        end
      end
      tick();
    end
    reqs = 8'h00;
    #1;
    checks++;
    if (grant_valid !== 1'b0 || grant !== 3'd0 || issue_entry !== 3'd7) begin
      failures++; $display("FAIL age_tail gv=%0b g=%0d ie=%0d want 0/0/7", grant_valid, grant, issue_entry);
    end
    tick();
    checks++;
    if (issue_valid !== 1'b0 || issue_count !== 32'd3) begin
      failures++; $display("FAIL age_count iv=%0b cnt=%0d want 0/3", issue_valid, issue_count);
    end
    do_retire(3'd5); do_retire(3'd2); do_retire(3'd7);
  endtask

  task automatic test_stall();
    do_alloc(3'd3); do_alloc(3'd0); do_alloc(3'd6);
    issue_ready = 1'b0; reqs = 8'hFF;
    #1;
    checks++;
    if (grant_valid !== 1'b1 || grant !== 3'd3) begin
      failures++; $display("FAIL stall_first gv=%0b g=%0d want 1/3", grant_valid, grant);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      retire_valid = (k == 1);
      retire_entry = 3'd3;
      #1;
      checks++;
      if (issue_valid !== 1'b1 || issue_entry !== 3'd3 || grant_valid !== 1'b0) begin
        failures++; $display("FAIL stall_hold%0d iv=%0b ie=%0d gv=%0b want 1/3/0", k, issue_valid, issue_entry, grant_valid);
      end
      tick();
    end
    retire_valid = 1'b0;
    issue_ready = 1'b1; reqs = 8'hF7;
    #1;
    checks++;
    if (grant_valid !== 1'b1 || grant !== 3'd0 || issue_entry !== 3'd3) begin
      failures++; $display("FAIL stall_release gv=%0b g=%0d ie=%0d want 1/0/3", grant_valid, grant, issue_entry);
    end
    tick();
    checks++;
    if (issue_valid !== 1'b1 || issue_entry !== 3'd0 || issue_count !== 32'd4) begin
      failures++; $display("FAIL stall_next iv=%0b ie=%0d cnt=%0d want 1/0/4", issue_valid, issue_entry, issue_count);
    end
    reqs = 8'h40;
    #1;
    checks++;
    if (grant_valid !== 1'b1 || grant !== 3'd6) begin
      failures++; $display("FAIL stall_b2b gv=%0b g=%0d want 1/6", grant_valid, grant);
    end
    tick();
    reqs = 8'h00;
    tick();
    checks++;
    if (issue_valid !== 1'b0 || issue_count !== 32'd6) begin
      failures++; $display("FAIL stall_count iv=%0b cnt=%0d want 0/6", issue_valid, issue_count);
    end
    do_retire(3'd0); do_retire(3'd6);
  endtask

  task automatic test_alloc_retire_diff();
    do_alloc(3'd1);
    alloc_valid = 1'b1; alloc_entry = 3'd4;
    retire_valid = 1'b1; retire_entry = 3'd1;
    tick();
    alloc_valid = 1'b0; retire_valid = 1'b0;
    issue_ready = 1'b1; reqs = 8'h12;
    #1;
    checks++;
    if (grant_valid !== 1'b1 || grant !== 3'd4) begin
      failures++; $display("FAIL diff_grant gv=%0b g=%0d want 1/4", grant_valid, grant);
    end
    tick();
    reqs = 8'h02;
    #1;
    checks++;
    if (grant_valid !== 1'b0 || issue_entry !== 3'd4) begin
      failures++; $display("FAIL diff_ignored gv=%0b ie=%0d want 0/4", grant_valid, issue_entry);
    end
    tick();
    reqs = 8'h00;
    checks++;
    if (issue_valid !== 1'b0 || issue_count !== 32'd7) begin
      failures++; $display("FAIL diff_count iv=%0b cnt=%0d want 0/7", issue_valid, issue_count);
    end
    do_retire(3'd4);
  endtask

  task automatic test_alloc_retire_same();
    do_alloc(3'd6); do_alloc(3'd3);
    alloc_valid = 1'b1; alloc_entry = 3'd6;
    retire_valid = 1'b1; retire_entry = 3'd6;
    tick();
    alloc_valid = 1'b0; retire_valid = 1'b0;
    issue_ready = 1'b1; reqs = 8'h48;
    #1;
    checks++;
    if (grant_valid !== 1'b1 || grant !== 3'd3) begin
      failures++; $display("FAIL same_older gv=%0b g=%0d want 1/3", grant_valid, grant);
    end
    tick();
    reqs = 8'h40;
    #1;
    checks++;
    if (grant_valid !== 1'b1 || grant !== 3'd6) begin
      failures++; $display("FAIL same_valid gv=%0b g=%0d want 1/6", grant_valid, grant);
    end
    tick();
    reqs = 8'h00;
    tick();
    checks++;
    if (issue_valid !== 1'b0 || issue_count !== 32'd9) begin
      failures++; $display("FAIL same_count iv=%0b cnt=%0d want 0/9", issue_valid, issue_count);
    end
    do_retire(3'd3); do_retire(3'd6);
  endtask

  task automatic test_reset_mid();
    do_alloc(3'd1);
    issue_ready = 1'b0; reqs = 8'h02;
    tick();
    #1;
    checks++;
    if (issue_valid !== 1'b1 || issue_entry !== 3'd1) begin
      failures++; $display("FAIL mid_pre iv=%0b ie=%0d want 1/1", issue_valid, issue_entry);
    end
    #2;
    rst = 1'b0; issue_ready = 1'b1;
    #1;
    checks++;
    if (issue_valid !== 1'b0 || issue_entry !== 3'd0 || issue_count !== 32'd0 || grant_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_async iv=%0b ie=%0d cnt=%0d gv=%0b want 0/0/0/0", issue_valid, issue_entry, issue_count, grant_valid);
    end
    #2;
    rst = 1'b1; reqs = 8'h00;
    tick();
  endtask

  task automatic test_wrap();
    do_alloc(3'd5);
    force dut.r_issue_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_issue_count;
    issue_ready = 1'b1; reqs = 8'h20;
    tick();
    reqs = 8'h00;
    checks++;
    if (issue_valid !== 1'b1 || issue_count !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL wrap_pre iv=%0b cnt=%0h want 1/ffffffff", issue_valid, issue_count);
    end
    tick();
    checks++;
    if (issue_valid !== 1'b0 || issue_count !== 32'd0) begin
      failures++; $display("FAIL wrap_zero iv=%0b cnt=%0h want 0/0", issue_valid, issue_count);
    end
    do_retire(3'd5);
  endtask

  initial begin
    test_reset();
    test_age_order();
    test_stall();
    test_alloc_retire_diff();
    test_alloc_retire_same();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
